// File: rtl/read_burst_arbiter.sv
// read_burst_arbiter: round-robin sharing of one AXI4 read-address channel among NUM_CH read-FIFO controllers.
// Optional watchdog on the ADDR/DATA phases: define RD_ARB_TIMEOUT_EN (limit given by TIMEOUT).
module read_burst_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int LSIZE   = 9,
    parameter int IDW     = 3,
    parameter int TIMEOUT = 4096
) (
    input  logic                    clock,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       burst_req,
    input  logic [NUM_CH-1:0]       tail_req,
    input  logic [NUM_CH*LSIZE-1:0] req_len,
    output logic [NUM_CH-1:0]       resp,
    output logic [NUM_CH-1:0]       done,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    output logic [7:0]              m_arlen,
    output logic [IDW-1:0]          m_arid,
    input  logic                    r_beat,
    input  logic                    r_last,
    output logic [IDW-1:0]          grant_ch,
    output logic                    busy,
    output logic [2:0]              err_flags
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_ZRESP = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    if ((NUM_CH < 1) || (NUM_CH > 8) || ((1 << IDW) < NUM_CH) || (TIMEOUT < 1)) begin : g_bad_cfg
        $error("read_burst_arbiter: illegal parameter combination");
    end

    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [IDW-1:0] ch);
        return NUM_CH'(1'b1) << ch;
    endfunction

    // Returns {valid, channel}: first requester at or after rr, wrapping.
    function automatic logic [IDW:0] pick_next(input logic [NUM_CH-1:0] req, input logic [IDW-1:0] rr);
        logic [2*NUM_CH-1:0] dbl;
        int                  off;
        int                  tmp;
        dbl = {req, req} >> rr;
        off = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (dbl[i]) begin
                off = i;
            end else begin
                off = off;
            end
        end
        tmp = int'(rr) + off;
        if (tmp >= NUM_CH) begin
            tmp = tmp - NUM_CH;
        end else begin
            tmp = tmp;
        end
        return {|req, IDW'(tmp)};
    endfunction

    // Lengths above one AXI4 burst are clamped to 256 beats.
    function automatic logic [8:0] clamp_len(input logic [LSIZE-1:0] len);
        if (32'(len) > 32'd256) begin
            return 9'd256;
        end else begin
            return 9'(len);
        end
    endfunction

    state_t              state_q, state_d;
    logic [IDW-1:0]      ch_q, ch_d;
    logic [IDW-1:0]      rr_q, rr_d;
    logic [8:0]          len_q, len_d;
    logic [8:0]          beat_q, beat_d;
    logic                arvalid_q, arvalid_d;
    logic [7:0]          arlen_q, arlen_d;
    logic [NUM_CH-1:0]   done_q, done_d;
    logic                zresp_q, zresp_d;
    logic                busy_q, busy_d;
    logic [2:0]          err_q, err_d;

    logic [IDW:0]        pick_s;
    logic                sel_vld_s;
    logic [IDW-1:0]      sel_ch_s;
    logic [LSIZE-1:0]    sel_len_raw_s;
    logic [8:0]          sel_len_s;
    logic                hs_s;

`ifdef RD_ARB_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0]      wd_q, wd_d;
`endif

    // Next-state and next-output computation for the arbiter FSM.
    always_comb begin
        pick_s        = pick_next(burst_req | tail_req, rr_q);
        sel_vld_s     = pick_s[IDW];
        sel_ch_s      = pick_s[IDW-1:0];
        sel_len_raw_s = LSIZE'(req_len >> (int'(sel_ch_s) * LSIZE));
        sel_len_s     = clamp_len(sel_len_raw_s);
        hs_s          = arvalid_q & m_arready;

        state_d   = state_q;
        ch_d      = ch_q;
        rr_d      = rr_q;
        len_d     = len_q;
        beat_d    = beat_q;
        arvalid_d = arvalid_q;
        arlen_d   = arlen_q;
        done_d    = '0;
        zresp_d   = 1'b0;
        busy_d    = busy_q;
        err_d     = err_q;
`ifdef RD_ARB_TIMEOUT_EN
        wd_d      = wd_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (sel_vld_s) begin
                    ch_d   = sel_ch_s;
                    len_d  = sel_len_s;
                    rr_d   = (sel_ch_s == IDW'(NUM_CH - 1)) ? '0 : sel_ch_s + IDW'(1);
                    beat_d = 9'd0;
                    busy_d = 1'b1;
`ifdef RD_ARB_TIMEOUT_EN
                    wd_d   = '0;
`endif
                    if (32'(sel_len_raw_s) > 32'd256) begin
                        err_d[0] = 1'b1;
                    end else begin
                        err_d[0] = err_q[0];
                    end
                    // Zero-length requests are acknowledged without touching the bus.
                    if (sel_len_s == 9'd0) begin
                        state_d = ST_ZRESP;
                        zresp_d = 1'b1;
                    end else begin
                        state_d   = ST_ADDR;
                        arvalid_d = 1'b1;
                        arlen_d   = 8'(sel_len_s - 9'd1);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (hs_s) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_DATA;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (r_beat) begin
                    beat_d = beat_q + 9'd1;
                    if (r_last) begin
                        state_d = ST_DONE;
                        done_d  = ch_onehot(ch_q);
                        if ((beat_q + 9'd1) != len_q) begin
                            err_d[1] = 1'b1;
                        end else begin
                            err_d[1] = err_q[1];
                        end
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_ZRESP: begin
                state_d = ST_DONE;
                done_d  = ch_onehot(ch_q);
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d   = ST_IDLE;
                arvalid_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase

`ifdef RD_ARB_TIMEOUT_EN
        // Watchdog: a handshake or last beat in the final cycle still wins.
        if (((state_q == ST_ADDR) && !hs_s) || ((state_q == ST_DATA) && !(r_beat && r_last))) begin
            wd_d = wd_q + WDW'(1);
            if (wd_q == WDW'(TIMEOUT - 1)) begin
                state_d   = ST_DONE;
                arvalid_d = 1'b0;
                done_d    = ch_onehot(ch_q);
                err_d[2]  = 1'b1;
            end else begin
                err_d[2] = err_q[2];
            end
        end else begin
            wd_d = wd_d;
        end
`endif
    end

    // State and output registers; reset aborts any transaction silently.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ch_q      <= '0;
            rr_q      <= '0;
            len_q     <= 9'd0;
            beat_q    <= 9'd0;
            arvalid_q <= 1'b0;
            arlen_q   <= 8'd0;
            done_q    <= '0;
            zresp_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 3'b000;
`ifdef RD_ARB_TIMEOUT_EN
            wd_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            rr_q      <= rr_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            arvalid_q <= arvalid_d;
            arlen_q   <= arlen_d;
            done_q    <= done_d;
            zresp_q   <= zresp_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
`ifdef RD_ARB_TIMEOUT_EN
            wd_q      <= wd_d;
`endif
        end
    end

    // resp must coincide with the AR handshake, so it is decoded from registered state and m_arready.
    assign resp      = (zresp_q | hs_s) ? ch_onehot(ch_q) : '0;
    assign done      = done_q;
    assign m_arvalid = arvalid_q;
    assign m_arlen   = arlen_q;
    assign m_arid    = ch_q;
    assign grant_ch  = ch_q;
    assign busy      = busy_q;
    assign err_flags = err_q;

endmodule

// File: tb/tb_read_burst_arbiter.sv
// Scoreboard bench for read_burst_arbiter: expected AR/resp/done events are queued at stimulus time
// and compared by a negedge monitor that also acts as the R-channel responder.
module tb_read_burst_arbiter;

    logic        clock;
    logic        rst_n;
    logic [1:0]  burst_req;
    logic [1:0]  tail_req;
    logic [17:0] req_len;
    logic [1:0]  resp;
    logic [1:0]  done;
    logic        m_arvalid;
    logic        m_arready;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arid;
    logic        r_beat;
    logic        r_last;
    logic [2:0]  grant_ch;
    logic        busy;
    logic [2:0]  err_flags;

    read_burst_arbiter #(.NUM_CH(2), .LSIZE(9), .IDW(3), .TIMEOUT(64)) dut (
        .clock(clock), .rst_n(rst_n), .burst_req(burst_req), .tail_req(tail_req),
        .req_len(req_len), .resp(resp), .done(done), .m_arvalid(m_arvalid),
        .m_arready(m_arready), .m_arlen(m_arlen), .m_arid(m_arid), .r_beat(r_beat),
        .r_last(r_last), .grant_ch(grant_ch), .busy(busy), .err_flags(err_flags)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int ch;
        int arlen;
        int send;
    } ar_t;

    ar_t exp_ar[$];
    int  exp_z[$];
    int  exp_done[$];
    int  rr_model;
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] oh(input int ch);
        return 2'b01 << ch;
    endfunction

    // Queue what the arbiter must do for one granted request, in grant order.
    task automatic expect_txn(input int ch, input int len, input int send, input bit with_done);
        int eff;
        eff = (len > 256) ? 256 : len;
        if (len == 0) exp_z.push_back(ch);
        else exp_ar.push_back('{ch, eff - 1, send});
        if (with_done) exp_done.push_back(ch);
        rr_model = (ch + 1) % 2;
    endtask

    task automatic set_req(input int ch, input int len, input bit tail);
        req_len[ch*9 +: 9] = 9'(len);
        if (tail) tail_req[ch] = 1'b1;
        else burst_req[ch] = 1'b1;
    endtask

    // Release each request after its resp and wait (bounded) for n done pulses.
    task automatic wait_dones(input int n);
        int got;
        int cyc;
        logic [1:0] clr;
        got = 0;
        cyc = 0;
        while (got < n && cyc < 2000) begin
            @(negedge clock);
            clr = resp;
            if (done != 2'b00) got++;
            @(posedge clock);
            #1;
            burst_req = burst_req & ~clr;
            tail_req  = tail_req & ~clr;
            cyc++;
        end
        check("wait_dones", 32'(got), 32'(n));
    endtask

    // Monitor and R responder.
    initial begin
        int  beats_left;
        int  beats_pend;
        bit  hs;
        bit  last_prev;
        ar_t e;
        int  c;
        beats_left = 0;
        beats_pend = 0;
        last_prev  = 1'b0;
        r_beat     = 1'b0;
        r_last     = 1'b0;
        forever begin
            @(negedge clock);
            hs = m_arvalid && m_arready;
            check("resp_done_onehot", 32'($countones(resp | done) <= 1), 32'd1);
            if (last_prev) check("done_after_last", 32'(done != 2'b00), 32'd1);
            last_prev = 1'b0;
            if (hs) begin
                if (exp_ar.size() == 0) begin
                    check("unexpected_ar", 32'd1, 32'd0);
                    beats_pend = 0;
                end else begin
                    e = exp_ar.pop_front();
                    check("arid", 32'(m_arid), 32'(e.ch));
                    check("arlen", 32'(m_arlen), 32'(e.arlen));
                    check("resp_at_hs", 32'(resp), 32'(oh(e.ch)));
                    beats_pend = e.send;
                end
            end else if (resp != 2'b00) begin
                if (exp_z.size() == 0) begin
                    check("unexpected_resp", 32'(resp), 32'd0);
                end else begin
                    c = exp_z.pop_front();
                    check("zero_len_resp", 32'(resp), 32'(oh(c)));
                end
            end
            if (done != 2'b00) begin
                if (exp_done.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    c = exp_done.pop_front();
                    check("done_ch", 32'(done), 32'(oh(c)));
                end
            end
            if (!rst_n) beats_left = 0;
            if (beats_left > 0) begin
                r_beat    = 1'b1;
                r_last    = (beats_left == 1);
                last_prev = r_last;
                beats_left--;
            end else begin
                r_beat = 1'b0;
                r_last = 1'b0;
            end
            if (hs && rst_n) beats_left = beats_pend;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not end");
        $fatal(1, "global timeout");
    end

    initial begin
        int f;
        int cnt;
        bit fell;
        rst_n     = 1'b0;
        burst_req = 2'b00;
        tail_req  = 2'b00;
        req_len   = 18'd0;
        m_arready = 1'b1;
        rr_model  = 0;

        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_arvalid", 32'(m_arvalid), 32'd0);
        check("rst_resp_done", 32'({resp, done}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err_flags), 32'd0);
        check("rst_grant_arlen", 32'({grant_ch, m_arlen, m_arid}), 32'd0);
        @(posedge clock);
        #1;
        rst_n = 1'b1;

        // 1: single ch0 burst, len 200.
        expect_txn(0, 200, 200, 1'b1);
        set_req(0, 200, 1'b0);
        @(negedge clock);
        check("t1_arvalid_before", 32'(m_arvalid), 32'd0);
        @(negedge clock);
        check("t1_arvalid_after", 32'(m_arvalid), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_grant", 32'(grant_ch), 32'd0);
        @(posedge clock);
        #1;
        burst_req[0] = 1'b0;
        wait_dones(1);

        // 2: simultaneous pairs, order follows the rotating pointer.
        f = rr_model;
        expect_txn(f, (f == 0) ? 5 : 7, (f == 0) ? 5 : 7, 1'b1);
        expect_txn(1 - f, (f == 0) ? 7 : 5, (f == 0) ? 7 : 5, 1'b1);
        set_req(0, 5, 1'b0);
        set_req(1, 7, 1'b0);
        wait_dones(2);
        f = rr_model;
        expect_txn(f, (f == 0) ? 3 : 4, (f == 0) ? 3 : 4, 1'b1);
        expect_txn(1 - f, (f == 0) ? 4 : 3, (f == 0) ? 4 : 3, 1'b1);
        set_req(0, 3, 1'b1);
        burst_req[0] = 1'b1;
        set_req(1, 4, 1'b0);
        wait_dones(2);

        // 3: ch1 tail len 37 with AR stalled for 5 cycles.
        m_arready = 1'b0;
        expect_txn(1, 37, 37, 1'b1);
        set_req(1, 37, 1'b1);
        @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("t3_stall_arvalid", 32'(m_arvalid), 32'd1);
            check("t3_stall_arlen_id", 32'({m_arlen, m_arid}), 32'({8'd36, 3'd1}));
            check("t3_stall_no_resp", 32'(resp), 32'd0);
        end
        @(posedge clock);
        #1;
        m_arready = 1'b1;
        wait_dones(1);
        check("t3_err_clear", 32'(err_flags), 32'd0);

        // 4: zero length then over-long length.
        expect_txn(0, 0, 0, 1'b1);
        set_req(0, 0, 1'b0);
        wait_dones(1);
        check("t4_zero_no_err", 32'(err_flags), 32'd0);
        expect_txn(1, 300, 256, 1'b1);
        set_req(1, 300, 1'b0);
        wait_dones(1);
        check("t4_clamp_err", 32'(err_flags), 32'b001);

        // 5: early r_last, then reset in the middle of DATA.
        expect_txn(0, 16, 10, 1'b1);
        set_req(0, 16, 1'b0);
        wait_dones(1);
        check("t5_beat_err", 32'(err_flags), 32'b011);
        expect_txn(1, 50, 50, 1'b0);
        set_req(1, 50, 1'b0);
        @(negedge clock);
        @(negedge clock);
        @(posedge clock);
        #1;
        burst_req[1] = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        rst_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("t5_rst_arvalid_busy", 32'({m_arvalid, busy}), 32'd0);
        check("t5_rst_resp_done", 32'({resp, done}), 32'd0);
        check("t5_rst_err", 32'(err_flags), 32'd0);
        check("t5_rst_grant_arlen", 32'({grant_ch, m_arlen}), 32'd0);
        @(posedge clock);
        #1;
        rst_n    = 1'b1;
        rr_model = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("t5_no_done_after_rst", 32'({done, busy}), 32'd0);
        end
        @(posedge clock);
        #1;

`ifdef RD_ARB_TIMEOUT_EN
        // 6: watchdog with AR never accepted.
        m_arready = 1'b0;
        exp_done.push_back(0);
        rr_model = 1;
        set_req(0, 8, 1'b0);
        cnt  = 0;
        fell = 1'b0;
        for (int i = 0; i < 200 && !fell; i++) begin
            @(negedge clock);
            if (m_arvalid) cnt++;
            else if (cnt > 0) fell = 1'b1;
        end
        check("t6_arvalid_cycles", 32'(cnt), 32'd64);
        check("t6_done", 32'(done), 32'b01);
        check("t6_timeout_err", 32'(err_flags[2]), 32'd1);
        @(posedge clock);
        #1;
        burst_req = 2'b00;
        m_arready = 1'b1;
`else
        cnt  = 0;
        fell = 1'b0;
        f    = cnt + (fell ? 1 : 0);
        check("no_timeout_err", 32'(err_flags[2]), 32'd0);
`endif

        repeat (4) @(negedge clock);
        check("exp_ar_drained", 32'(exp_ar.size()), 32'd0);
        check("exp_z_drained", 32'(exp_z.size()), 32'd0);
        check("exp_done_drained", 32'(exp_done.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
